muldiv6_seq: RTL and testbench
==============================

MULDIV6_SEQ -- requirements
Module: muldiv6_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 6, meaning operand width in bits; result width is 2*WIDTH.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand request.
REQ-006 SHALL have port op  input  1  operation select: 0 multiply, 1 divide.
REQ-007 SHALL have port a  input  WIDTH  multiplicand / dividend, unsigned.
REQ-008 SHALL have port b  input  WIDTH  multiplier / divisor, unsigned.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port result  output  2*WIDTH  multiply: product; divide: {remainder, quotient}.
REQ-012 SHALL have port dbz  output  1  divide-by-zero flag, qualified by out_valid.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE with in_valid=1, capture a, b, op on that edge, clear the step counter, and enter RUN.
REQ-016 SHALL perform one iteration per cycle in RUN and enter DONE on the edge completing iteration WIDTH, so out_valid rises exactly WIDTH edges after the accepting edge (6 for the default), for either op and any operand values.
REQ-017 SHALL, for multiply, use right-shift shift-add: when the current multiplier LSB is 1, add the multiplicand to the upper WIDTH bits of the 2*WIDTH accumulator with carry-out kept, then shift right by one.
REQ-018 SHALL produce result = a*b exactly, unsigned, 2*WIDTH bits, with no truncation.
REQ-019 SHALL, for divide, use restoring division (shift-left partial remainder, trial subtract, restore on borrow), giving quotient = floor(a/b) in result[WIDTH-1:0] and remainder = a mod b in result[2*WIDTH-1:WIDTH].
REQ-020 SHALL, for divide with b=0, output quotient all-ones, remainder=a, and dbz=1, with the same latency as REQ-016.
REQ-021 SHALL hold result and dbz stable in DONE until out_valid and out_ready are both 1, then return to IDLE on that edge.
REQ-022 SHALL ignore in_valid in RUN and DONE; a request presented there SHALL NOT be captured and SHALL NOT alter the in-flight result.
REQ-023 SHALL NOT allow pass-through: in_ready is 0 in the cycle of the output handshake, and a new request is accepted no earlier than the following cycle.
REQ-024 SHALL keep dbz=0 for multiply operations.

Reset
REQ-025 SHALL, while rst=1 at a rising edge, enter IDLE and set in_ready=1, out_valid=0, result=0, dbz=0, counter=0, regardless of in_valid or out_ready.
REQ-026 SHALL, on reset asserted in RUN or DONE, discard the in-flight operation with no result ever presented for it.

Configuration
REQ-027 SHALL compile divide support only when macro MULDIV6_SEQ_DIV_EN is defined.
REQ-028 SHALL, with MULDIV6_SEQ_DIV_EN defined, behave per REQ-019/020.
REQ-029 SHALL, without MULDIV6_SEQ_DIV_EN, treat every request as multiply (op ignored), tie dbz to 0, and contain no subtract/restore logic; multiply timing is unchanged.

Verification
REQ-030 SHALL cover: op=0, a=63, b=63 -> result=12'hF81 (3969), dbz=0, out_valid 6 edges after acceptance.
REQ-031 SHALL cover: op=0, a=0, b=45 -> result=12'h000; then a=1, b=1 -> result=12'h001.
REQ-032 SHALL cover (DIV_EN defined): op=1, a=50, b=7 -> result=12'h047 (rem 1, quot 7), dbz=0.
REQ-033 SHALL cover (DIV_EN defined): op=1, a=13, b=0 -> result=12'h37F (rem 13, quot 63), dbz=1; without DIV_EN the same stimulus -> result=12'h000, dbz=0.
REQ-034 SHALL cover: out_ready held 0 for 10 cycles in DONE with in_valid pulsed -> result stable, in_ready=0, no capture; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-035 SHALL cover: rst=1 for one edge at RUN iteration 3 -> next cycle in_ready=1, out_valid=0, result=0; the following request completes with a correct result.

Source files
------------

// File: rtl/muldiv6_seq.sv
// rtl/muldiv6_seq.sv - sequential unsigned multiplier / restoring divider, one iteration per cycle
//
// Purpose: computes a*b (shift-add) or, when built with MULDIV6_SEQ_DIV_EN
// defined, {a mod b, a / b} (restoring division) over WIDTH cycles.
// Optional feature macro: MULDIV6_SEQ_DIV_EN (divide support; when it is
// undefined every request is a multiply and dbz is tied to 0).
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand request valid
//   in_ready   out  block is idle and can accept a request
//   op         in   0 multiply, 1 divide
//   a          in   multiplicand / dividend (unsigned, WIDTH)
//   b          in   multiplier / divisor (unsigned, WIDTH)
//   out_valid  out  result valid
//   out_ready  in   consumer accepts the result
//   result     out  product, or {remainder, quotient} (2*WIDTH)
//   dbz        out  divide-by-zero flag, qualified by out_valid

module muldiv6_seq #(
    parameter int WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 dbz
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    // Multiply: {partial product high half, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     opnd_q;      // multiplicand or divisor
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [2*WIDTH-1:0]   result_q;
    logic                 dbz_q;

    logic [2*WIDTH-1:0]   acc_d;
    logic [2*WIDTH-1:0]   acc_init_d;
    logic [WIDTH-1:0]     opnd_init_d;
    logic                 dbz_init_d;

    // Shift-add step: carry out of the high-half add lands in the MSB after the shift.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    end

`ifdef MULDIV6_SEQ_DIV_EN
    logic                 op_q;
    logic                 dbz_run_q;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_next;

    // Partial remainder stays below the divisor, so the trial difference fits
    // in WIDTH bits when it does not borrow and its MSB is the borrow flag.
    always_comb begin
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd_q};
        if (div_diff[WIDTH])
            div_next = {acc_q[2*WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        dbz_init_d = op && (b == '0);
        if (!op) begin
            acc_init_d  = {{WIDTH{1'b0}}, b};
            opnd_init_d = a;
        end else if (b == '0) begin
            // Divide by zero: final answer is preloaded and held through RUN
            // so latency matches a normal operation.
            acc_init_d  = {a, {WIDTH{1'b1}}};
            opnd_init_d = b;
        end else begin
            acc_init_d  = {{WIDTH{1'b0}}, a};
            opnd_init_d = b;
        end

        if (!op_q)
            acc_d = mul_next;
        else if (dbz_run_q)
            acc_d = acc_q;
        else
            acc_d = div_next;
    end
`else
    logic unused_op;
    assign unused_op = op;

    always_comb begin
        dbz_init_d  = 1'b0;
        acc_init_d  = {{WIDTH{1'b0}}, b};
        opnd_init_d = a;
        acc_d       = mul_next;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            dbz_q       <= 1'b0;
`ifdef MULDIV6_SEQ_DIV_EN
            op_q        <= 1'b0;
            dbz_run_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_q      <= acc_init_d;
                        opnd_q     <= opnd_init_d;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
`ifdef MULDIV6_SEQ_DIV_EN
                        op_q       <= op;
                        dbz_run_q  <= dbz_init_d;
`endif
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        result_q    <= acc_d;
                        dbz_q       <= dbz_init_q_sel();
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Flag for the operation currently in RUN.
    function automatic logic dbz_init_q_sel();
`ifdef MULDIV6_SEQ_DIV_EN
        return dbz_run_q;
`else
        return 1'b0;
`endif
    endfunction

`ifndef MULDIV6_SEQ_DIV_EN
    logic unused_dbz_init;
    assign unused_dbz_init = dbz_init_d;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign dbz       = dbz_q;

endmodule

// File: tb/tb_muldiv6_seq.sv
// tb/tb_muldiv6_seq.sv - self-checking bench for muldiv6_seq against an arithmetic reference model
module tb_muldiv6_seq;

    localparam int W = 6;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            op = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [2*W-1:0]  result;
    logic            dbz;

    int n_cmp  = 0;
    int n_fail = 0;

    muldiv6_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain arithmetic on the request as the block should interpret it.
    function automatic void model(input logic mop, input int ma, input int mb,
                                  output logic [2*W-1:0] r, output logic z);
        int q, m;
        z = 1'b0;
        r = (2*W)'(ma * mb);
`ifdef MULDIV6_SEQ_DIV_EN
        if (mop) begin
            if (mb == 0) begin
                q = (1 << W) - 1;
                m = ma;
                z = 1'b1;
            end else begin
                q = ma / mb;
                m = ma % mb;
            end
            r = (2*W)'((m << W) | q);
        end
`endif
    endfunction

    // Full transaction: accept, measure latency, check, handshake out.
    task automatic run_op(input string tag, input logic mop, input int ma, input int mb);
        logic [2*W-1:0] er;
        logic           ez;
        int             lat;
        model(mop, ma, mb, er, ez);
        check({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = mop; a = W'(ma); b = W'(mb);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd6);
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " dbz"}, 32'(dbz), 32'(ez));
        check({tag, " in_ready done"}, 32'(in_ready), 32'd0);
        // Offer a new request in the handshake cycle; it must not pass through.
        out_ready = 1'b1; in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
        tick();
        out_ready = 1'b0; in_valid = 1'b0;
        check({tag, " out_valid after hs"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after hs"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [2*W-1:0] er, held;
        logic           ez;
        int             ra, rb, lat;
        logic           rop;

        // Reset with noisy handshake inputs.
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst result", 32'(result), 32'd0);
        check("rst dbz", 32'(dbz), 32'd0);
        rst = 1'b0;
        tick();

        // Directed cases, expected values written out by hand.
        model(1'b0, 63, 63, er, ez);
        check("const 63*63", 32'(er), 32'h0F81);
        run_op("mul 63*63", 1'b0, 63, 63);
        run_op("mul 0*45", 1'b0, 0, 45);
        run_op("mul 1*1", 1'b0, 1, 1);
        run_op("div 50/7", 1'b1, 50, 7);
        run_op("div 13/0", 1'b1, 13, 0);
        run_op("div 63/1", 1'b1, 63, 1);
        run_op("div 5/63", 1'b1, 5, 63);
        run_op("mul 63*1", 1'b0, 63, 1);

        // Stall in DONE with stray requests.
        model(1'b0, 37, 29, er, ez);
        in_valid = 1'b1; op = 1'b0; a = 6'd37; b = 6'd29;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin tick(); lat++; end
        check("stall latency", 32'(lat), 32'd6);
        held = result;
        check("stall result", 32'(held), 32'(er));
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; a = W'($urandom); b = W'($urandom); op = 1'($urandom);
            tick();
            check("stall hold result", 32'(result), 32'(er));
            check("stall in_ready", 32'(in_ready), 32'd0);
            check("stall out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall release in_ready", 32'(in_ready), 32'd1);
        check("stall release out_valid", 32'(out_valid), 32'd0);

        // Reset mid-RUN, then no stale result may appear.
        in_valid = 1'b1; op = 1'b0; a = 6'd55; b = 6'd44;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst result", 32'(result), 32'd0);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) lat++;
        end
        check("midrst no stale result", 32'(lat), 32'd0);
        run_op("after rst 21*3", 1'b0, 21, 3);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            rop = 1'($urandom);
            ra  = int'($urandom_range(0, 63));
            rb  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 63));
            run_op("rand", rop, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
